platform_hex_bank: RTL and testbench

PLATFORM_HEX_BANK -- requirements
Module: platform_hex_bank

---
 rtl/platform_hex_bank.sv | 147 ++++++++++++++
 tb/tb_platform_hex_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/platform_hex_bank.sv
// platform_hex_bank: Avalon-MM register bank driving NUM_DIGITS seven-segment
// digits, with per-digit hex decode, blank and blink control.
module platform_hex_bank #(
    parameter int NUM_DIGITS     = 6,
    parameter int BLINK_DIV      = 25000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] out_port,
    output logic                    blink_phase
);

    localparam int               CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    localparam logic [3:0] ADDR_BLINK = 4'd8;
    localparam logic [3:0] ADDR_BLANK = 4'd9;
    localparam logic [3:0] ADDR_VALUE = 4'd10;

    logic [7:0]            dig_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blink_q;
    logic [NUM_DIGITS-1:0] blank_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [7*NUM_DIGITS-1:0] seg_d;
    logic                  wr_en;
    logic                  unused_wdata;

    assign wr_en = chipselect & ~write_n;

    // Not every writedata bit lands in a register for small NUM_DIGITS.
    assign unused_wdata = ^writedata;

    // Lit pattern (g..a) for a hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Lit pattern of a DIG register: decoded nibble when DEC is set, else raw bits.
    function automatic logic [6:0] lit_of(input logic [7:0] d);
        return d[7] ? hex_decode(d[3:0]) : d[6:0];
    endfunction

    // Register file writes; VALUE fans one word out to every digit at once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                dig_q[k] <= '0;
            end
            blink_q <= '0;
            blank_q <= '0;
        end else if (wr_en) begin
            if (address == ADDR_VALUE) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    dig_q[k] <= {1'b1, 3'b000, writedata[4*k +: 4]};
                end
            end else if (address == ADDR_BLINK) begin
                blink_q <= writedata[NUM_DIGITS-1:0];
            end else if (address == ADDR_BLANK) begin
                blank_q <= writedata[NUM_DIGITS-1:0];
            end else begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (address == 4'(k)) begin
                        dig_q[k] <= writedata[7:0];
                    end
                end
            end
        end
    end

    // Free-running blink timer; phase flips on the wrap edge, writes never touch it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            blink_phase <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Per-digit segment drive from the current registers and phase.
    always_comb begin
        seg_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (blank_q[k] || (blink_q[k] && blink_phase)) begin
                seg_d[7*k +: 7] = SEG_OFF;
            end else if (SEG_ACTIVE_LOW) begin
                seg_d[7*k +: 7] = ~lit_of(dig_q[k]);
            end else begin
                seg_d[7*k +: 7] = lit_of(dig_q[k]);
            end
        end
    end

    // Registered segment outputs; reset shows every digit off.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_port <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            out_port <= seg_d;
        end
    end

    // Zero-latency read mux; VALUE and unimplemented addresses read 0.
    always_comb begin
        readdata = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (address == 4'(k)) begin
                readdata = {24'b0, dig_q[k]};
            end
        end
        if (address == ADDR_BLINK) begin
            readdata[NUM_DIGITS-1:0] = blink_q;
        end else if (address == ADDR_BLANK) begin
            readdata[NUM_DIGITS-1:0] = blank_q;
        end
    end

endmodule

// File: tb/tb_platform_hex_bank.sv
// Bench for platform_hex_bank: a 6-digit and a 4-digit build share one bus and
// are checked every cycle against a register-level model, plus literal checks.
module tb_platform_hex_bank;

    localparam int BD = 4;

    localparam logic [6:0] HEX_LIT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = 4'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;

    logic [31:0] rd_a, rd_b;
    logic [41:0] out_a;
    logic [27:0] out_b;
    logic        ph_a, ph_b;

    always #5 clk = ~clk;

    platform_hex_bank #(.NUM_DIGITS(6), .BLINK_DIV(BD), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .out_port(out_a), .blink_phase(ph_a)
    );

    platform_hex_bank #(.NUM_DIGITS(4), .BLINK_DIV(BD), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b),
        .out_port(out_b), .blink_phase(ph_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0]  m_dig [2][8];
    logic [7:0]  m_blink [2];
    logic [7:0]  m_blank [2];
    int          m_cyc = 0;
    bit          m_valid = 1'b0;
    logic [41:0] e_out_a;
    logic [27:0] e_out_b;
    logic [55:0] tmp_out;
    bit          pre_phase;

    function automatic int nd_of(input int i);
        return (i == 0) ? 6 : 4;
    endfunction

    function automatic bit model_phase();
        return ((m_cyc / BD) % 2) == 1;
    endfunction

    function automatic logic [55:0] expect_out(input int i, input bit ph);
        logic [55:0] r;
        logic [6:0]  lit;
        r = '0;
        for (int k = 0; k < nd_of(i); k++) begin
            if (m_blank[i][k] || (m_blink[i][k] && ph)) begin
                r[7*k +: 7] = 7'h7F;
            end else begin
                lit = m_dig[i][k][7] ? HEX_LIT[m_dig[i][k][3:0]] : m_dig[i][k][6:0];
                r[7*k +: 7] = ~lit;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input int i, input logic [3:0] a);
        if (int'(a) < nd_of(i)) return {24'b0, m_dig[i][a]};
        if (a == 4'd8) return {24'b0, m_blink[i]};
        if (a == 4'd9) return {24'b0, m_blank[i]};
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        pre_phase = model_phase();
        if (!reset_n) begin
            e_out_a = '1;
            e_out_b = '1;
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 8; k++) m_dig[i][k] = 8'h00;
                m_blink[i] = 8'h00;
                m_blank[i] = 8'h00;
            end
            m_cyc   = 0;
            m_valid = 1'b1;
        end else begin
            tmp_out = expect_out(0, pre_phase);
            e_out_a = tmp_out[41:0];
            tmp_out = expect_out(1, pre_phase);
            e_out_b = tmp_out[27:0];
            if (chipselect && !write_n) begin
                for (int i = 0; i < 2; i++) begin
                    if (address == 4'd10) begin
                        for (int k = 0; k < nd_of(i); k++)
                            m_dig[i][k] = {4'b1000, writedata[4*k +: 4]};
                    end else if (address == 4'd8) begin
                        m_blink[i] = writedata[7:0] & 8'((1 << nd_of(i)) - 1);
                    end else if (address == 4'd9) begin
                        m_blank[i] = writedata[7:0] & 8'((1 << nd_of(i)) - 1);
                    end else if (int'(address) < nd_of(i)) begin
                        m_dig[i][address] = writedata[7:0];
                    end
                end
            end
            m_cyc++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("rd_a", 64'(rd_a), 64'(exp_rd(0, address)));
            check("rd_b", 64'(rd_b), 64'(exp_rd(1, address)));
            check("out_a", 64'(out_a), 64'(e_out_a));
            check("out_b", 64'(out_b), 64'(e_out_b));
            check("phase_a", 64'(ph_a), 64'(model_phase()));
            check("phase_b", 64'(ph_b), 64'(model_phase()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    int toggles;
    logic prev_ph;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        check("reset_out_all_off", 64'(out_a), 64'(42'h3FF_FFFF_FFFF));
        for (int a = 0; a <= 10; a++) begin
            address = 4'(a);
            @(negedge clk);
            check("reset_read_zero", 64'(rd_a), 64'd0);
        end

        wr(4'd0, 32'h85);
        address = 4'd0;
        @(negedge clk);
        check("dig0_read", 64'(rd_a), 64'h85);
        check("dig0_not_yet", 64'(out_a[6:0]), 64'h7F);
        @(negedge clk);
        check("dig0_seg", 64'(out_a[6:0]), 64'h12);

        wr(4'd10, 32'h00AB_CDEF);
        address = 4'd0;
        @(negedge clk);
        check("value_dig0", 64'(rd_a), 64'h8F);
        address = 4'd5;
        @(negedge clk);
        check("value_dig5", 64'(rd_a), 64'h8A);
        check("value_out", 64'(out_a),
              64'({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}));

        wr(4'd1, 32'h88);
        wr(4'd9, 32'h02);
        repeat (2) @(negedge clk);
        check("blank_dig1", 64'(out_a[13:7]), 64'h7F);
        wr(4'd9, 32'h00);
        repeat (2) @(negedge clk);
        check("unblank_dig1", 64'(out_a[13:7]), 64'h00);

        // Ignored accesses: chipselect low, then VALUE/unused readbacks.
        @(posedge clk); #1;
        address = 4'd2; writedata = 32'hFF; write_n = 1'b0; chipselect = 1'b0;
        @(posedge clk); #1;
        write_n = 1'b1;
        wr(4'd11, 32'hFFFF_FFFF);
        wr(4'd15, 32'h1234_5678);

        wr(4'd8, 32'h01);
        @(negedge clk);
        prev_ph = ph_a;
        toggles = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (ph_a !== prev_ph) toggles++;
            prev_ph = ph_a;
        end
        check("blink_toggles", 64'(toggles), 64'd4);

        // Reset mid-blink together with a write to DIG0.
        @(posedge clk); #1;
        reset_n = 1'b0; chipselect = 1'b1; write_n = 1'b0; address = 4'd0; writedata = 32'h55;
        @(posedge clk); #1;
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);
        check("reset_beats_write", 64'(rd_a), 64'd0);

        wr(4'd8, 32'h3F);
        wr(4'd0, 32'h80);
        wr(4'd5, 32'h12);
        address = 4'd5;
        @(negedge clk);
        check("b_addr5_read", 64'(rd_b), 64'd0);
        check("a_addr5_read", 64'(rd_a), 64'h12);
        repeat (10) @(negedge clk);

        wr(4'd10, 32'h7654_3210);
        wr(4'd9, 32'h0000_0024);
        wr(4'd3, 32'h0000_0049);
        address = 4'd9;
        repeat (12) @(negedge clk);
        check("b_blank_masked", 64'(rd_b), 64'h04);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
